// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the fetch-stage instruction memory.
package instr_mem_pkg;

  typedef enum logic [0:0] {
    IM_INIT = 1'b0,
    IM_RUN  = 1'b1
  } im_state_t;

  // One byte lane of a byte-enable merge: take the new byte where enabled.
  function automatic logic [7:0] be_merge(input logic [7:0] old_byte,
                                          input logic [7:0] new_byte,
                                          input logic       be);
    logic [7:0] res;
    if (be) begin
      res = new_byte;
    end else begin
      res = old_byte;
    end
    return res;
  endfunction

  // A byte address is bad when misaligned or beyond the 2**aw word window.
  function automatic logic addr_bad(input logic [31:0] addr, input int aw);
    logic [31:0] hi;
    hi = addr >> (aw + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'h0000_0000);
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x DATA_WIDTH storage: one byte-enable write port, one async read port.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [ADDR_WIDTH-1:0]   rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] merged_s;

  // Build the word to store: new bytes where enabled, old bytes elsewhere.
  always_comb begin
    merged_s = mem[wr_idx];
    for (int i = 0; i < NBYTES; i++) begin
      merged_s[8*i +: 8] = be_merge(mem[wr_idx][8*i +: 8], wr_data[8*i +: 8], wr_be[i]);
    end
  end

  // Single-cycle write port; the array itself carries no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= merged_s;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/instr_mem_fetch.sv
// Fetch-stage instruction memory: self-initialising after reset, registered
// read with stall hold, byte-enable write port with write-first forwarding.
module instr_mem_fetch
  import instr_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] INIT_WORD  = {DATA_WIDTH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_req,
  input  logic [31:0]             fetch_addr,
  input  logic                    fetch_stall,
  output logic                    fetch_valid,
  output logic [DATA_WIDTH-1:0]   fetch_instr,
  output logic                    fetch_err,
  input  logic                    wr_en,
  input  logic [31:0]             wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  output logic                    wr_err,
  output logic                    busy
);

  localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
  localparam int                    NBYTES   = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  im_state_t               state_r;
  logic [ADDR_WIDTH-1:0]   init_cnt_r;

  logic [ADDR_WIDTH-1:0]   fetch_idx_s;
  logic [ADDR_WIDTH-1:0]   wr_idx_s;
  logic                    fetch_bad_s;
  logic                    wr_bad_s;
  logic                    fetch_ok_s;
  logic                    wr_ok_s;
  logic                    arr_we_s;
  logic [ADDR_WIDTH-1:0]   arr_idx_s;
  logic [DATA_WIDTH-1:0]   arr_data_s;
  logic [NBYTES-1:0]       arr_be_s;
  logic [DATA_WIDTH-1:0]   rd_data_s;
  logic [DATA_WIDTH-1:0]   fwd_data_s;

  // Decode addresses, qualify requests, and steer the array write port
  // between the INIT fill and the external write port.
  always_comb begin
    fetch_idx_s = fetch_addr[ADDR_WIDTH+1:2];
    wr_idx_s    = wr_addr[ADDR_WIDTH+1:2];
    fetch_bad_s = addr_bad(fetch_addr, ADDR_WIDTH);
    wr_bad_s    = addr_bad(wr_addr, ADDR_WIDTH);
    fetch_ok_s  = fetch_req & ~busy;
    wr_ok_s     = wr_en & ~busy & ~wr_bad_s;
    if (busy) begin
      arr_we_s   = 1'b1;
      arr_idx_s  = init_cnt_r;
      arr_data_s = INIT_WORD;
      arr_be_s   = {NBYTES{1'b1}};
    end else begin
      arr_we_s   = wr_ok_s;
      arr_idx_s  = wr_idx_s;
      arr_data_s = wr_data;
      arr_be_s   = wr_be;
    end
  end

  // Write-first forwarding: a same-index write in this cycle is visible to the fetch.
  always_comb begin
    fwd_data_s = rd_data_s;
    if (wr_ok_s && (wr_idx_s == fetch_idx_s)) begin
      for (int i = 0; i < NBYTES; i++) begin
        fwd_data_s[8*i +: 8] = be_merge(rd_data_s[8*i +: 8], wr_data[8*i +: 8], wr_be[i]);
      end
    end else begin
      fwd_data_s = rd_data_s;
    end
  end

  instr_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .we      (arr_we_s),
    .wr_idx  (arr_idx_s),
    .wr_data (arr_data_s),
    .wr_be   (arr_be_s),
    .rd_idx  (fetch_idx_s),
    .rd_data (rd_data_s)
  );

  // INIT/RUN sequencing plus all registered fetch and write-status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IM_INIT;
      init_cnt_r  <= '0;
      busy        <= 1'b1;
      fetch_valid <= 1'b0;
      fetch_instr <= INIT_WORD;
      fetch_err   <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      case (state_r)
        IM_INIT: begin
          if (init_cnt_r == LAST_IDX) begin
            state_r    <= IM_RUN;
            init_cnt_r <= '0;
            busy       <= 1'b0;
          end else begin
            init_cnt_r <= init_cnt_r + ADDR_WIDTH'(1);
            busy       <= 1'b1;
          end
        end
        IM_RUN: begin
          busy <= 1'b0;
        end
        default: begin
          state_r    <= IM_INIT;
          init_cnt_r <= '0;
          busy       <= 1'b1;
        end
      endcase

      wr_err <= wr_en & (busy | wr_bad_s);

      if (!fetch_stall) begin
        fetch_valid <= fetch_ok_s;
        if (fetch_ok_s) begin
          if (fetch_bad_s) begin
            fetch_err   <= 1'b1;
            fetch_instr <= INIT_WORD;
          end else begin
            fetch_err   <= 1'b0;
            fetch_instr <= fwd_data_s;
          end
        end else begin
          fetch_err <= 1'b0;
        end
      end
    end
  end

endmodule
